bus_arbiter: RTL



---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter_rr_pick.sv | 24 ++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the two-requester bus arbiter: FSM encoding,
// requester indices and the default read data returned on a watchdog expiry.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam logic [31:0] ARB_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational grant selection for two requesters: a single request wins
// outright; a tie goes to m0 (fixed priority) or to whoever was not last granted.
module arb_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = ARB_M0;
    unique case (req)
      2'b10:   idx = ARB_M1;
      2'b11:   idx = (PRIO_FIXED != 0) ? ARB_M0 : ~last_grant;
      default: idx = ARB_M0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one req/ack memory port between two 4-phase level-handshake requesters,
// with round-robin or fixed-priority selection and an ack-timeout watchdog.
//
//   state      | meaning
//   ARB_IDLE   | no transaction; sample requests and grant
//   ARB_ACCESS | o_mem_req held high, waiting for ack or watchdog expiry
//   ARB_DONE   | owner's ready high until the owner drops its request
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       PRIO_FIXED = 0,
  parameter int unsigned       TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(ARB_ERR_DATA)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_ready,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_ready,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_owner,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e        state, state_next;
  logic              last_grant, grant_valid, grant_idx;
  logic              owner_req, aborted;
  logic              ack_hit, expire, finish;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_val;
  logic [CNT_W-1:0]  wd_cnt;

  arb_rr_pick #(.PRIO_FIXED(PRIO_FIXED)) u_pick (
    .req        ({i_m1_req, i_m0_req}),
    .last_grant (last_grant),
    .valid      (grant_valid),
    .idx        (grant_idx)
  );

  always_comb begin
    owner_req = (o_owner == ARB_M1) ? i_m1_req : i_m0_req;
    sel_we    = (grant_idx == ARB_M1) ? i_m1_we : i_m0_we;
    sel_addr  = (grant_idx == ARB_M1) ? i_m1_addr : i_m0_addr;
    sel_wdata = (grant_idx == ARB_M1) ? i_m1_wdata : i_m0_wdata;
    ack_hit   = (state == ARB_ACCESS) && i_mem_ack;
    // Watchdog is a down-counter loaded with TIMEOUT; terminal count 1 means
    // this edge is the TIMEOUT-th one without an ack. Ack on that edge wins.
    expire    = (state == ARB_ACCESS) && !i_mem_ack && (TIMEOUT != 0) &&
                (wd_cnt == CNT_W'(1));
    finish    = ack_hit || expire;
    rd_val    = ack_hit ? i_mem_rdata : ERR_DATA;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ARB_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:   if (grant_valid) state_next = ARB_ACCESS;
      ARB_ACCESS: if (finish) state_next = (aborted || !owner_req) ? ARB_IDLE : ARB_DONE;
      ARB_DONE:   if (!owner_req) state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != ARB_IDLE);
    o_m0_ready = (state == ARB_DONE) && (o_owner == ARB_M0);
    o_m1_ready = (state == ARB_DONE) && (o_owner == ARB_M1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_m0_rdata  <= '0;
      o_m1_rdata  <= '0;
      o_owner     <= ARB_M0;
      o_timeout   <= 1'b0;
      last_grant  <= ARB_M1;
      aborted     <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      o_timeout <= expire;
      if (state == ARB_IDLE && grant_valid) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= sel_we;
        o_mem_addr  <= sel_addr;
        o_mem_wdata <= sel_wdata;
        o_owner     <= grant_idx;
        last_grant  <= grant_idx;
        aborted     <= 1'b0;
        wd_cnt      <= CNT_W'(TIMEOUT);
      end
      if (state == ARB_ACCESS) begin
        if (!owner_req) aborted <= 1'b1;
        if (finish) begin
          o_mem_req <= 1'b0;
          if (!o_mem_we) begin
            if (o_owner == ARB_M1) o_m1_rdata <= rd_val;
            else                   o_m0_rdata <= rd_val;
          end
        end else if (TIMEOUT != 0) begin
          wd_cnt <= wd_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule
